// File: rtl/nn_ctrl_pkg.sv
// Shared types, default latencies and the layer-size field helper for the NN sequencer.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_AF    = 3'd3,
    ST_WRITE = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } nn_state_e;

  localparam int DEF_LOAD_EXTRA = 3;
  localparam int DEF_MAC_LAT    = 10;
  localparam int DEF_AF_LAT     = 32;

  // Upper bounds for the generic field extractor; callers zero-extend into these.
  localparam int unsigned SIZES_MAX_W = 512;
  localparam int unsigned FIELD_MAX_W = 16;

  // Return field k (nw bits wide) of a packed per-layer array; out-of-range k yields 0.
  function automatic logic [FIELD_MAX_W-1:0] layer_field(
    input logic [SIZES_MAX_W-1:0] sizes,
    input int unsigned            k,
    input int unsigned            nw
  );
    logic [SIZES_MAX_W-1:0] sh;
    logic [FIELD_MAX_W-1:0] fld;
    sh  = sizes >> (k * nw);
    fld = '0;
    for (int unsigned b = 0; b < FIELD_MAX_W; b++) begin
      if (b < nw) fld[b] = sh[b];
    end
    return fld;
  endfunction

endpackage

// File: rtl/nn_phase_counter.sv
// Loadable down-counter with enable and terminal-count flag, used to time LOAD/MAC/AF phases.
module nn_phase_counter #(
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_tc
);

  logic [CW-1:0] r_count;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/nn_layer_sequencer.sv
// Layer-by-layer inference sequencer: issues load/MAC/activation/output enables per layer and input.
module nn_layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter  int MAX_LAYERS = 8,
  parameter  int NW         = 6,
  parameter  int IW         = 10,
  parameter  int LOAD_EXTRA = DEF_LOAD_EXTRA,
  parameter  int MAC_LAT    = DEF_MAC_LAT,
  parameter  int AF_LAT     = DEF_AF_LAT,
  parameter  int CW         = 8,
  localparam int NLW        = $clog2(MAX_LAYERS + 1),
  localparam int LW         = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NLW-1:0]         no_layers,
  input  logic [MAX_LAYERS*NW-1:0] layer_sizes,
  input  logic [IW-1:0]          n_in,
  input  logic                   mem_ready,
  output logic                   weight_en,
  output logic                   bias_en,
  output logic                   compute_en,
  output logic                   af_en,
  output logic                   output_shft_en,
  output logic                   output_wr_en,
  output logic                   output_sel,
  output logic                   bias_sel,
  output logic                   layer_start,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output logic [LW-1:0]          layer,
  output logic [IW-1:0]          i
);

  nn_state_e r_state;
  nn_state_e w_nstate;

  logic [LW-1:0]            r_layer, w_nlayer;
  logic [IW-1:0]            r_i, w_ni;
  logic [NLW-1:0]           r_no_layers;
  logic [MAX_LAYERS*NW-1:0] r_sizes;
  logic [IW-1:0]            r_n_in;

  logic r_weight_en, r_bias_en, r_compute_en, r_af_en;
  logic r_shft, r_wr, r_out_sel, r_bias_sel, r_lstart;
  logic r_busy, r_done, r_cfg_err;

  logic          w_cnt_load, w_cnt_en, w_tc;
  logic [CW-1:0] w_cnt_val;
  logic          w_accept, w_cfg_chk, w_cfg_bad, w_last;
  logic          w_shft, w_lstart;

  logic [SIZES_MAX_W-1:0] w_sizes_in, w_sizes_lat;
  logic [NW-1:0]          w_fld_first, w_fld_cur, w_fld_next, w_fld_prev;
  logic [IW-1:0]          w_fm1;

  assign w_sizes_in  = SIZES_MAX_W'(layer_sizes);
  assign w_sizes_lat = SIZES_MAX_W'(r_sizes);

  assign w_fld_first = NW'(layer_field(w_sizes_in, 0, NW));
  assign w_fld_cur   = NW'(layer_field(w_sizes_lat, 32'(r_layer), NW));
  assign w_fld_next  = NW'(layer_field(w_sizes_lat, 32'(r_layer) + 32'd1, NW));
  assign w_fld_prev  = NW'(layer_field(w_sizes_lat, 32'(r_layer) - 32'd1, NW));

  // Last input index of the current layer: fan-in is n_in for layer 0, else previous layer size.
  assign w_fm1  = (r_layer == '0) ? r_n_in : IW'(w_fld_prev);
  assign w_last = ((NLW'(r_layer) + NLW'(1)) == r_no_layers);

  assign w_cfg_bad = (no_layers == '0) || (no_layers > NLW'(MAX_LAYERS));

  nn_phase_counter #(.CW(CW)) u_phase_cnt (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (w_cnt_en),
    .o_tc       (w_tc)
  );

  // Next-state, next-index and phase-counter control.
  always_comb begin
    w_nstate   = r_state;
    w_nlayer   = r_layer;
    w_ni       = r_i;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_en   = 1'b0;
    w_shft     = 1'b0;
    w_lstart   = 1'b0;
    w_accept   = 1'b0;
    w_cfg_chk  = 1'b0;
    if (abort) begin
      w_nstate = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_cfg_chk = 1'b1;
            if (w_cfg_bad) begin
              w_nstate = ST_IDLE;
            end else begin
              w_accept   = 1'b1;
              w_nstate   = ST_LOAD;
              w_nlayer   = '0;
              w_ni       = '0;
              w_cnt_load = 1'b1;
              w_cnt_val  = CW'(w_fld_first) + CW'(LOAD_EXTRA);
              w_lstart   = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (mem_ready) begin
            if (w_tc) begin
              w_nstate   = ST_MAC;
              w_cnt_load = 1'b1;
              w_cnt_val  = CW'(MAC_LAT - 1);
            end else begin
              w_cnt_en = 1'b1;
            end
          end
        end
        ST_MAC: begin
          if (w_tc) begin
            if (r_i != w_fm1) begin
              w_nstate   = ST_LOAD;
              w_ni       = r_i + IW'(1);
              w_cnt_load = 1'b1;
              w_cnt_val  = CW'(w_fld_cur) + CW'(LOAD_EXTRA);
              w_shft     = (r_layer != '0);
            end else begin
              w_nstate   = ST_AF;
              w_cnt_load = 1'b1;
              w_cnt_val  = CW'(AF_LAT - 1);
            end
          end else begin
            w_cnt_en = 1'b1;
          end
        end
        ST_AF: begin
          if (w_tc) w_nstate = ST_WRITE;
          else      w_cnt_en = 1'b1;
        end
        ST_WRITE: w_nstate = ST_NEXT;
        ST_NEXT: begin
          if (w_last) begin
            w_nstate = ST_DONE;
          end else begin
            w_nstate   = ST_LOAD;
            w_nlayer   = r_layer + LW'(1);
            w_ni       = '0;
            w_cnt_load = 1'b1;
            w_cnt_val  = CW'(w_fld_next) + CW'(LOAD_EXTRA);
            w_lstart   = 1'b1;
          end
        end
        default: w_nstate = ST_IDLE;
      endcase
    end
  end

  // State, indices, latched configuration and sticky config error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_layer     <= '0;
      r_i         <= '0;
      r_no_layers <= '0;
      r_sizes     <= '0;
      r_n_in      <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_layer <= w_nlayer;
      r_i     <= w_ni;
      if (w_accept) begin
        r_no_layers <= no_layers;
        r_sizes     <= layer_sizes;
        r_n_in      <= n_in;
      end
      if (w_cfg_chk) r_cfg_err <= w_cfg_bad;
    end
  end

  // Moore outputs decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weight_en  <= 1'b0;
      r_bias_en    <= 1'b0;
      r_compute_en <= 1'b0;
      r_af_en      <= 1'b0;
      r_shft       <= 1'b0;
      r_wr         <= 1'b0;
      r_out_sel    <= 1'b0;
      r_bias_sel   <= 1'b0;
      r_lstart     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_weight_en  <= (w_nstate == ST_LOAD);
      r_bias_en    <= (w_nstate == ST_LOAD);
      r_compute_en <= (w_nstate == ST_MAC) || (w_nstate == ST_AF);
      r_af_en      <= (w_nstate == ST_AF);
      r_shft       <= w_shft;
      r_wr         <= (w_nstate == ST_WRITE);
      r_out_sel    <= (w_nstate == ST_LOAD) && (w_nlayer != '0);
      r_bias_sel   <= (w_nstate == ST_LOAD) && (w_ni != '0);
      r_lstart     <= w_lstart;
      r_busy       <= (w_nstate != ST_IDLE) && (w_nstate != ST_DONE);
      r_done       <= (w_nstate == ST_DONE);
    end
  end

  assign weight_en      = r_weight_en;
  assign bias_en        = r_bias_en;
  assign compute_en     = r_compute_en;
  assign af_en          = r_af_en;
  assign output_shft_en = r_shft;
  assign output_wr_en   = r_wr;
  assign output_sel     = r_out_sel;
  assign bias_sel       = r_bias_sel;
  assign layer_start    = r_lstart;
  assign busy           = r_busy;
  assign done           = r_done;
  assign cfg_err        = r_cfg_err;
  assign layer          = r_layer;
  assign i              = r_i;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench: phase-list reference model, table-driven scenarios and random configs.
module tb_nn_layer_sequencer;

  localparam int MAXL = 8;
  localparam int NWB  = 6;
  localparam int IWB  = 10;
  localparam int LE   = 3;
  localparam int ML   = 10;
  localparam int AL   = 32;
  localparam int BUDGET = 20000;

  localparam int PH_LOAD = 0;
  localparam int PH_MAC  = 1;
  localparam int PH_AF   = 2;
  localparam int PH_WR   = 3;
  localparam int PH_NEXT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mem_ready = 1'b0;
  logic [3:0]  no_layers = '0;
  logic [47:0] layer_sizes = '0;
  logic [9:0]  n_in = '0;

  logic weight_en, bias_en, compute_en, af_en, output_shft_en, output_wr_en;
  logic output_sel, bias_sel, layer_start, busy, done, cfg_err;
  logic [2:0] layer;
  logic [9:0] i;

  nn_layer_sequencer #(
    .MAX_LAYERS(MAXL), .NW(NWB), .IW(IWB),
    .LOAD_EXTRA(LE), .MAC_LAT(ML), .AF_LAT(AL), .CW(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .no_layers(no_layers), .layer_sizes(layer_sizes), .n_in(n_in),
    .mem_ready(mem_ready),
    .weight_en(weight_en), .bias_en(bias_en), .compute_en(compute_en),
    .af_en(af_en), .output_shft_en(output_shft_en), .output_wr_en(output_wr_en),
    .output_sel(output_sel), .bias_sel(bias_sel), .layer_start(layer_start),
    .busy(busy), .done(done), .cfg_err(cfg_err), .layer(layer), .i(i)
  );

  always #5 clk = ~clk;

  logic [24:0] obs;
  assign obs = {weight_en, bias_en, compute_en, af_en, output_shft_en, output_wr_en,
                output_sel, bias_sel, layer_start, busy, done, cfg_err, layer, i};

  int checks = 0;
  int failures = 0;
  int last_layer = 0;
  int last_i = 0;
  int busy_cnt, wr_cnt, shft_cnt, ls_cnt;

  typedef struct {
    int kind;
    int layer;
    int idx;
    int len;
  } phase_t;

  typedef struct {
    string       nm;
    int          nl;
    logic [47:0] sz;
    int          nin;
    int          mode;     // 0 ready always, 1 ready alternating, 2 random
    int          abort_at;
    int          ign_at;
    int          e_busy;
    int          e_wr;
    int          e_shft;
    int          e_ls;
  } vec_t;

  function automatic logic [24:0] mk(input bit we, be, ce, afe, sh, wr, os, bs, ls, bz, dn, er,
                                     input int ly, input int ii);
    return {we, be, ce, afe, sh, wr, os, bs, ls, bz, dn, er, 3'(ly), 10'(ii)};
  endfunction

  function automatic int fld(input logic [47:0] s, input int k);
    logic [47:0] t;
    t = (s >> (NWB * k)) & 48'h3F;
    return int'(t);
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    phase_t      ph[$];
    phase_t      p;
    logic [24:0] e;
    int          cyc;
    int          f;
    bit          first;
    bit          m;
    bit          aborted;

    @(negedge clk);
    no_layers   = 4'(v.nl);
    layer_sizes = v.sz;
    n_in        = 10'(v.nin);
    start       = 1'b1;
    mem_ready   = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    layer_sizes = {$urandom, $urandom};
    n_in        = 10'($urandom);
    no_layers   = 4'($urandom);

    if (v.nl == 0 || v.nl > MAXL) begin
      e = mk(0,0,0,0,0,0,0,0,0,0,0,1, last_layer, last_i);
      chk({v.nm, " cfg_err"}, 0, obs, e);
      @(negedge clk);
      chk({v.nm, " cfg_err held"}, 1, obs, e);
      return;
    end

    for (int k = 0; k < v.nl; k++) begin
      f = (k == 0) ? v.nin + 1 : fld(v.sz, k - 1) + 1;
      for (int j = 0; j < f; j++) begin
        ph.push_back('{PH_LOAD, k, j, fld(v.sz, k) + 1 + LE});
        ph.push_back('{PH_MAC, k, j, ML});
      end
      ph.push_back('{PH_AF, k, f - 1, AL});
      ph.push_back('{PH_WR, k, f - 1, 1});
      ph.push_back('{PH_NEXT, k, f - 1, 1});
    end

    cyc = 0; first = 1'b1; aborted = 1'b0;
    busy_cnt = 0; wr_cnt = 0; shft_cnt = 0; ls_cnt = 0;
    while (ph.size() > 0 && cyc < BUDGET) begin
      p = ph[0];
      case (p.kind)
        PH_LOAD: e = mk(1, 1, 0, 0, first && p.idx != 0 && p.layer != 0, 0,
                        p.layer != 0, p.idx != 0, first && p.idx == 0, 1, 0, 0, p.layer, p.idx);
        PH_MAC:  e = mk(0,0,1,0,0,0,0,0,0,1,0,0, p.layer, p.idx);
        PH_AF:   e = mk(0,0,1,1,0,0,0,0,0,1,0,0, p.layer, p.idx);
        PH_WR:   e = mk(0,0,0,0,0,1,0,0,0,1,0,0, p.layer, p.idx);
        default: e = mk(0,0,0,0,0,0,0,0,0,1,0,0, p.layer, p.idx);
      endcase
      chk(v.nm, cyc, obs, e);
      busy_cnt += int'(busy);
      wr_cnt   += int'(output_wr_en);
      shft_cnt += int'(output_shft_en);
      ls_cnt   += int'(layer_start);
      last_layer = p.layer;
      last_i     = p.idx;
      if (cyc == v.abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk({v.nm, " abort"}, cyc, obs, mk(0,0,0,0,0,0,0,0,0,0,0,0, last_layer, last_i));
        aborted = 1'b1;
        break;
      end
      start = (cyc == v.ign_at);
      if (start) no_layers = 4'd1;
      case (v.mode)
        0:       m = 1'b1;
        1:       m = (cyc % 2 == 0);
        default: m = 1'($urandom_range(0, 1));
      endcase
      mem_ready = m;
      if (p.kind != PH_LOAD || m) p.len--;
      ph[0] = p;
      first = 1'b0;
      if (p.len == 0) begin
        void'(ph.pop_front());
        first = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    if (aborted) return;
    if (ph.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout after %0d cycles", v.nm, cyc);
      return;
    end
    e = mk(0,0,0,0,0,0,0,0,0,0,1,0, last_layer, last_i);
    chk({v.nm, " done"}, cyc, obs, e);
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk({v.nm, " done held"}, cyc + 1, obs, e);
    if (v.e_busy >= 0) chk_int({v.nm, " busy cycles"}, busy_cnt, v.e_busy);
    if (v.e_wr >= 0)   chk_int({v.nm, " wr pulses"}, wr_cnt, v.e_wr);
    if (v.e_shft >= 0) chk_int({v.nm, " shft pulses"}, shft_cnt, v.e_shft);
    if (v.e_ls >= 0)   chk_int({v.nm, " layer_start pulses"}, ls_cnt, v.e_ls);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"s2",    1, 48'h3,             1, 0, -1, -1,  68,  1,  0,  1};
    tbl[1] = '{"s3",    2, 48'hFC3,           0, 0, -1, -1, 393,  2,  3,  2};
    tbl[2] = '{"s4",    1, 48'h3,             1, 1, -1, -1,  -1,  1,  0,  1};
    tbl[3] = '{"abort", 1, 48'h3,             1, 0, 40, -1,  -1, -1, -1, -1};
    tbl[4] = '{"s5",    1, 48'h3,             1, 0, -1, -1,  68,  1,  0,  1};
    tbl[5] = '{"err0",  0, 48'h3,             1, 0, -1, -1,  -1, -1, -1, -1};
    tbl[6] = '{"err9",  9, 48'h3,             1, 0, -1, -1,  -1, -1, -1, -1};
    tbl[7] = '{"full8", 8, 48'hFC00_0100_2001, 2, 2, -1,  3,  -1,  8,  -1,  8};
    tbl[8] = '{"s2b",   1, 48'h3,             1, 2, -1,  2,  -1,  1,  0,  1};

    #12;
    chk("reset state", 0, obs, mk(0,0,0,0,0,0,0,0,0,0,0,0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset", 0, obs, mk(0,0,0,0,0,0,0,0,0,0,0,0, 0, 0));

    // Reset asserted in the middle of the first MAC phase.
    no_layers = 4'd1; layer_sizes = 48'h3; n_in = 10'd1; mem_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid MAC", 10, obs, mk(0,0,1,0,0,0,0,0,0,1,0,0, 0, 0));
    rst_n = 1'b0;
    #1;
    chk("async reset", 10, obs, mk(0,0,0,0,0,0,0,0,0,0,0,0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after mid reset", 0, obs, mk(0,0,0,0,0,0,0,0,0,0,0,0, 0, 0));
    last_layer = 0;
    last_i     = 0;

    for (int t = 0; t < 9; t++) run(tbl[t]);

    for (int r = 0; r < 6; r++) begin
      rv.nm   = "rand";
      rv.nl   = $urandom_range(1, 4);
      rv.sz   = '0;
      for (int k = 0; k < MAXL; k++)
        rv.sz = rv.sz | (48'($urandom_range(0, 7)) << (NWB * k));
      rv.nin  = $urandom_range(0, 3);
      rv.mode = 2;
      rv.abort_at = (r == 4) ? 25 : -1;
      rv.ign_at   = $urandom_range(0, 6);
      rv.e_busy = -1;
      rv.e_wr   = (r == 4) ? -1 : rv.nl;
      rv.e_shft = -1;
      rv.e_ls   = (r == 4) ? -1 : rv.nl;
      run(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
